// File: rtl/fullchip_pkg.sv
// Shared definitions for the fullchip host-side sequencer: inst word layout and FSM encoding.
package fullchip_pkg;

    localparam int INST_W        = 19;

    localparam int INST_ACC      = 18;
    localparam int INST_DIV      = 17;
    localparam int INST_OFIFO_RD = 16;
    localparam int QKADD_MSB     = 15;
    localparam int QKADD_LSB     = 12;
    localparam int PADD_MSB      = 11;
    localparam int PADD_LSB      = 8;
    localparam int INST_EXECUTE  = 7;
    localparam int INST_LOAD     = 6;
    localparam int INST_QMEM_RD  = 5;
    localparam int INST_QMEM_WR  = 4;
    localparam int INST_KMEM_RD  = 3;
    localparam int INST_KMEM_WR  = 2;
    localparam int INST_PMEM_RD  = 1;
    localparam int INST_PMEM_WR  = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QWR   = 3'd1,
        KWR   = 3'd2,
        KLOAD = 3'd3,
        EXEC  = 3'd4,
        DRAIN = 3'd5,
        ORD   = 3'd6,
        DONE  = 3'd7
    } state_e;

endpackage

// File: rtl/fullchip_inst_seq.sv
// Host-side instruction sequencer: streams Q/K vectors into fullchip memories, then walks
// the K-load, execute, drain and ofifo-to-pmem phases, emitting one registered inst word per cycle.
module fullchip_inst_seq
    import fullchip_pkg::*;
#(
    parameter int col         = 8,
    parameter int bw          = 8,
    parameter int pr          = 16,
    parameter int total_cycle = 8,
    parameter int drain_cycle = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [pr*bw-1:0]    data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [pr*bw-1:0]    mem_in,
    output logic [INST_W-1:0]   inst,
    output logic                busy,
    output logic                done
);

    localparam logic [4:0] TC_LAST  = 5'(total_cycle - 1);
    localparam logic [4:0] TC_END   = 5'(total_cycle);
    localparam logic [4:0] COL_LAST = 5'(col - 1);
    localparam logic [4:0] COL_END  = 5'(col);
    localparam logic [4:0] DR_LAST  = 5'(drain_cycle - 1);

    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [pr*bw-1:0]    mem_in_q, mem_in_d;
    logic                data_ready_q, data_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                beat;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inst_d   = '0;
        mem_in_d = mem_in_q;
        // data_ready_q is high exactly while the state is QWR or KWR
        beat     = data_valid && data_ready_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = QWR;
                    cnt_d   = '0;
                end
            end
            QWR: begin
                if (beat) begin
                    inst_d[INST_QMEM_WR]         = 1'b1;
                    inst_d[QKADD_MSB:QKADD_LSB]  = cnt_q[3:0];
                    mem_in_d                     = data_in;
                    if (cnt_q == TC_LAST) begin
                        state_d = KWR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
            end
            KWR: begin
                if (beat) begin
                    inst_d[INST_KMEM_WR]         = 1'b1;
                    inst_d[QKADD_MSB:QKADD_LSB]  = cnt_q[3:0];
                    mem_in_d                     = data_in;
                    if (cnt_q == COL_LAST) begin
                        state_d = KLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
            end
            KLOAD: begin
                // load trails kmem_rd by one cycle to cover the memory read latency
                if (cnt_q < COL_END) begin
                    inst_d[INST_KMEM_RD]         = 1'b1;
                    inst_d[QKADD_MSB:QKADD_LSB]  = cnt_q[3:0];
                end
                if (cnt_q != 5'd0) begin
                    inst_d[INST_LOAD] = 1'b1;
                end
                if (cnt_q == COL_END) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            EXEC: begin
                if (cnt_q < TC_END) begin
                    inst_d[INST_QMEM_RD]         = 1'b1;
                    inst_d[QKADD_MSB:QKADD_LSB]  = cnt_q[3:0];
                end
                if (cnt_q != 5'd0) begin
                    inst_d[INST_EXECUTE] = 1'b1;
                end
                if (cnt_q == TC_END) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == DR_LAST) begin
                    state_d = ORD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            ORD: begin
                if (cnt_q < TC_END) begin
                    inst_d[INST_OFIFO_RD] = 1'b1;
                end
                if (cnt_q != 5'd0) begin
                    inst_d[INST_PMEM_WR]       = 1'b1;
                    inst_d[PADD_MSB:PADD_LSB]  = 4'(cnt_q - 5'd1);
                end
                if (cnt_q == TC_END) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        data_ready_d = (state_d == QWR) || (state_d == KWR);
        busy_d       = (state_q != IDLE) && (state_q != DONE);
        done_d       = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            inst_q       <= '0;
            mem_in_q     <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inst_q       <= inst_d;
            mem_in_q     <= mem_in_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign data_ready = data_ready_q;
    assign mem_in     = mem_in_q;
    assign inst       = inst_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// Bench for fullchip_inst_seq: two configurations driven by directed runs with random data/valid.
module tb_fullchip_inst_seq;
    import fullchip_pkg::*;

    localparam int PW = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_a, start_b;
    logic            data_valid;
    logic [PW-1:0]   data_in;

    logic [PW-1:0]   mem_in_a, mem_in_b;
    logic [18:0]     inst_a, inst_b;
    logic            ready_a, ready_b, busy_a, busy_b, done_a, done_b;

    logic            sel;
    logic [PW-1:0]   o_mem;
    logic [18:0]     o_inst;
    logic            o_ready, o_busy, o_done;

    int              checks = 0;
    int              failures = 0;
    int              ticks = 0;
    logic [PW-1:0]   exp_mem;

    always #5 clk = ~clk;

    fullchip_inst_seq #(.col(8), .bw(8), .pr(16), .total_cycle(8), .drain_cycle(10)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_a), .mem_in(mem_in_a), .inst(inst_a), .busy(busy_a), .done(done_a)
    );

    fullchip_inst_seq #(.col(4), .bw(8), .pr(16), .total_cycle(2), .drain_cycle(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_b), .mem_in(mem_in_b), .inst(inst_b), .busy(busy_b), .done(done_b)
    );

    always_comb begin
        o_mem   = sel ? mem_in_b : mem_in_a;
        o_inst  = sel ? inst_b   : inst_a;
        o_ready = sel ? ready_b  : ready_a;
        o_busy  = sel ? busy_b   : busy_a;
        o_done  = sel ? done_b   : done_a;
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Advance one edge, sample 1 ns later, and check the always-true inst properties.
    task automatic tick();
        int groups;
        @(posedge clk);
        #1;
        ticks++;
        groups = int'(o_inst[INST_QMEM_WR]) + int'(o_inst[INST_KMEM_WR])
               + int'(o_inst[INST_KMEM_RD] | o_inst[INST_LOAD])
               + int'(o_inst[INST_QMEM_RD] | o_inst[INST_EXECUTE])
               + int'(o_inst[INST_OFIFO_RD] | o_inst[INST_PMEM_WR]);
        chk("group_excl", PW'(groups <= 1), 1);
        chk("zero_fields", {o_inst[INST_ACC], o_inst[INST_DIV], o_inst[INST_PMEM_RD]}, 0);
    endtask

    // vmode: 0 valid always, 1 valid toggling 1,0,1,0..., 2 random valid.
    task automatic run(input int c, input int t, input int d, input int vmode,
                       input bit inj_start, input bit abort, input bit keep_start);
        logic [18:0]   q[$];
        logic [18:0]   w;
        logic [PW-1:0] dat;
        bit            v;
        int            beats;
        int            cyc;

        // Expected instruction stream after the last K beat, from the phase rules.
        for (int k = 0; k <= c; k++) begin
            w = '0;
            if (k < c) begin w[INST_KMEM_RD] = 1'b1; w[15:12] = 4'(k); end
            if (k >= 1) w[INST_LOAD] = 1'b1;
            q.push_back(w);
        end
        for (int k = 0; k <= t; k++) begin
            w = '0;
            if (k < t) begin w[INST_QMEM_RD] = 1'b1; w[15:12] = 4'(k); end
            if (k >= 1) w[INST_EXECUTE] = 1'b1;
            q.push_back(w);
        end
        for (int k = 0; k < d; k++) q.push_back(19'd0);
        for (int k = 0; k <= t; k++) begin
            w = '0;
            if (k < t) w[INST_OFIFO_RD] = 1'b1;
            if (k >= 1) begin w[INST_PMEM_WR] = 1'b1; w[11:8] = 4'(k - 1); end
            q.push_back(w);
        end

        set_start(1'b1);
        data_valid = 1'($urandom_range(0, 1));
        data_in    = rnd();
        ticks      = 0;
        tick();
        if (!keep_start) set_start(1'b0);
        chk("start_ready", PW'(o_ready), 1);
        chk("start_inst", PW'(o_inst), 0);
        chk("start_mem", o_mem, exp_mem);
        chk("start_done", PW'(o_done), 0);

        beats = 0;
        cyc   = 0;
        while (beats < t + c && cyc < 200) begin
            chk("wr_ready", PW'(o_ready), 1);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            dat        = rnd();
            data_valid = v;
            data_in    = dat;
            tick();
            cyc++;
            w = '0;
            if (v) begin
                if (beats < t) begin w[INST_QMEM_WR] = 1'b1; w[15:12] = 4'(beats); end
                else begin w[INST_KMEM_WR] = 1'b1; w[15:12] = 4'(beats - t); end
                exp_mem = dat;
                beats++;
            end
            chk("wr_inst", PW'(o_inst), PW'(w));
            chk("wr_mem", o_mem, exp_mem);
            chk("wr_busy", PW'(o_busy), 1);
        end
        if (beats < t + c) begin
            chk("wr_timeout", PW'(beats), PW'(t + c));
            return;
        end

        for (int i = 0; i < q.size(); i++) begin
            data_valid = 1'($urandom_range(0, 1));
            data_in    = rnd();
            if (inj_start) set_start((i == c + 2) || keep_start);
            tick();
            chk("post_inst", PW'(o_inst), PW'(q[i]));
            chk("post_mem", o_mem, exp_mem);
            chk("post_ready", PW'(o_ready), 0);
            chk("post_busy", PW'(o_busy), 1);
            chk("post_done", PW'(o_done), 0);
            if (abort && i == c / 2) begin
                #3 reset = 1'b1;
                #1;
                chk("abort_inst", PW'(o_inst), 0);
                chk("abort_mem", o_mem, 0);
                chk("abort_busy", PW'(o_busy), 0);
                chk("abort_ready", PW'(o_ready), 0);
                chk("abort_done", PW'(o_done), 0);
                exp_mem = '0;
                set_start(1'b0);
                data_valid = 1'b0;
                @(posedge clk);
                #1 reset = 1'b0;
                tick();
                chk("abort_idle", {o_busy, o_ready, o_done, o_inst}, 0);
                return;
            end
        end

        data_valid = 1'($urandom_range(0, 1));
        data_in    = rnd();
        tick();
        chk("done_pulse", PW'(o_done), 1);
        chk("done_inst", PW'(o_inst), 0);
        chk("done_busy", PW'(o_busy), 0);
        chk("done_ready", PW'(o_ready), 0);
        chk("done_mem", o_mem, exp_mem);
        if (vmode == 0) chk("run_length", PW'(ticks), PW'(2 * c + 3 * t + d + 5));
        $display("run col=%0d tc=%0d drain=%0d vmode=%0d inj=%0d keep=%0d ticks=%0d",
                 c, t, d, vmode, inj_start, keep_start, ticks);
        if (!keep_start) begin
            tick();
            chk("done_once", PW'(o_done), 0);
            chk("idle_busy", PW'(o_busy), 0);
            chk("idle_ready", PW'(o_ready), 0);
        end
    endtask

    initial begin
        sel        = 1'b0;
        reset      = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        exp_mem    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", {o_busy, o_ready, o_done, o_inst, o_mem[7:0]}, 0);
        chk("rst_a_mem", o_mem, 0);
        sel = 1'b1;
        #1;
        chk("rst_b", {o_busy, o_ready, o_done, o_inst}, 0);
        chk("rst_b_mem", o_mem, 0);
        sel = 1'b0;
        reset = 1'b0;
        tick();
        chk("idle_after_rst", {o_busy, o_ready, o_done, o_inst}, 0);

        run(8, 8, 10, 0, 1'b0, 1'b0, 1'b0);   // full-rate run, 55 cycles
        run(8, 8, 10, 1, 1'b0, 1'b0, 1'b0);   // stalled beats
        run(8, 8, 10, 0, 1'b1, 1'b0, 1'b0);   // start during EXEC ignored
        run(8, 8, 10, 2, 1'b0, 1'b1, 1'b0);   // async reset mid-KLOAD
        run(8, 8, 10, 0, 1'b0, 1'b0, 1'b0);   // restart from address 0
        run(8, 8, 10, 2, 1'b0, 1'b0, 1'b1);   // start held through done
        run(8, 8, 10, 2, 1'b0, 1'b0, 1'b0);

        sel     = 1'b1;
        exp_mem = '0;
        run(4, 2, 1, 0, 1'b0, 1'b0, 1'b0);
        run(4, 2, 1, 2, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
